// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state
// encoding and the default operand width.
package seq_multiplier_pkg;

  localparam int DEFAULT_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : seq_multiplier_pkg

// File: rtl/seq_multiplier_fulladder32.sv
// Combinational BITS-wide ripple adder with carry in/out. The multiplier
// feeds it the partial product and the gated multiplicand each iteration.
module fulladder32 #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  input  logic            p_i,
  output logic [BITS-1:0] s_o,
  output logic            p_o
);

  assign {p_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{BITS{1'b0}}, p_i};

endmodule : fulladder32

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: BITS x BITS -> 2*BITS product,
// one adder pass per clock, start/busy/valid handshake.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [BITS-1:0]   a_i,
  input  logic [BITS-1:0]   b_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [2*BITS-1:0] product_o
);

  localparam int CNT_W = $clog2(BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITS - 1);

  state_e           state_q, state_d;
  logic [BITS-1:0]  mcand_q, mcand_d;
  logic [BITS-1:0]  hi_q,    hi_d;
  logic [BITS-1:0]  lo_q,    lo_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [BITS-1:0]  add_b;
  logic [BITS-1:0]  add_s;
  logic             add_p;

  // Multiplicand is added only when the current multiplier bit (lo LSB) is set.
  assign add_b = lo_q[0] ? mcand_q : '0;

  fulladder32 #(.BITS(BITS)) u_adder (
    .a_i (hi_q),
    .b_i (add_b),
    .p_i (1'b0),
    .s_o (add_s),
    .p_o (add_p)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the value.
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mcand_d = a_i;
          hi_d    = '0;
          lo_d    = b_i;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Adder carry lands in hi MSB; S LSB shifts into lo as the multiplier retires.
        hi_d    = {add_p, add_s[BITS-1:1]};
        lo_d    = {add_s[0], lo_q[BITS-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  assign busy_o    = (state_q == ST_RUN);
  assign valid_o   = (state_q == ST_DONE);
  assign product_o = {hi_q, lo_q};

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: scoreboard of a*b products pushed at
// start, compared at every valid_o pulse; directed corner cases then a random run.
module tb_seq_multiplier;

  localparam int BITS = 32;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic [BITS-1:0]   a_i;
  logic [BITS-1:0]   b_i;
  logic              busy_o;
  logic              valid_o;
  logic [2*BITS-1:0] product_o;

  int n_vec  = 0;
  int n_err  = 0;
  int n_valid = 0;

  logic [2*BITS-1:0] exp_q[$];
  logic [2*BITS-1:0] exp_v;

  bit spacing_en = 1'b0;
  bit seen_first = 1'b0;
  int gap        = 0;

  seq_multiplier #(.BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .product_o (product_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*BITS-1:0] got,
                       input logic [2*BITS-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*BITS-1:0] mul_model(input logic [BITS-1:0] a,
                                                   input logic [BITS-1:0] b);
    return {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
  endfunction

  // Scoreboard monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      n_valid++;
      check("busy_in_done", {63'b0, busy_o}, 64'd0);
      if (exp_q.size() == 0) begin
        check("spurious_valid", {63'b0, valid_o}, 64'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check("product", product_o, exp_v);
      end
    end
    // Pulses are BITS+2 edges apart when start is held, i.e. BITS+1 low cycles between.
    if (spacing_en) begin
      if (valid_o) begin
        if (seen_first) check("valid_gap", 64'(gap), 64'(BITS + 1));
        seen_first = 1'b1;
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  task automatic start_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    exp_q.push_back(mul_model(a, b));
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  // Returns at the negedge where valid_o is seen; counts cycles and busy cycles.
  task automatic wait_valid(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy_o) busy_cnt++;
    end while (!valid_o && lat < 200);
    if (!valid_o) check("valid_timeout", {63'b0, valid_o}, 64'd1);
  endtask

  task automatic run_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    int lat, bc;
    start_op(a, b);
    wait_valid(lat, bc);
    @(negedge clk);
  endtask

  initial begin
    int lat, bc, pulses0, drain;

    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",    {63'b0, busy_o},  64'd0);
    check("rst_valid",   {63'b0, valid_o}, 64'd0);
    check("rst_product", product_o,        64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: latency and busy duration
    start_op(32'd3, 32'd5);
    wait_valid(lat, bc);
    check("latency_3x5", 64'(lat), 64'(BITS + 1));
    check("busy_cycles", 64'(bc),  64'(BITS));
    check("result_3x5",  product_o, 64'h0000_0000_0000_000F);
    @(negedge clk);
    check("idle_busy",   {63'b0, busy_o},  64'd0);
    check("idle_valid",  {63'b0, valid_o}, 64'd0);

    // 2, 3: full-scale and edge operands
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("hold_max", product_o, 64'hFFFF_FFFE_0000_0001);
    run_op(32'h0, 32'hDEAD_BEEF);
    check("hold_zero", product_o, 64'h0);
    run_op(32'h8000_0000, 32'd2);
    check("hold_msb", product_o, 64'h0000_0001_0000_0000);

    // 4: start pulses while running and in DONE are ignored
    pulses0 = n_valid;
    start_op(32'd7, 32'd9);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start_i = 1'b0;
      if (lat == 5) begin
        start_i = 1'b1; a_i = 32'd1; b_i = 32'd1;
      end
    end while (!valid_o && lat < 200);
    check("latency_7x9", 64'(lat), 64'(BITS + 1));
    start_i = 1'b1; a_i = 32'd1; b_i = 32'd1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (40) @(negedge clk);
    check("single_pulse", 64'(n_valid - pulses0), 64'd1);
    check("ignored_start", product_o, 64'd63);

    // 5: reset mid-run aborts without a result
    pulses0 = n_valid;
    start_op(32'd7, 32'd9);
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy",    {63'b0, busy_o},  64'd0);
    check("abort_valid",   {63'b0, valid_o}, 64'd0);
    check("abort_product", product_o,        64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_pulse", 64'(n_valid - pulses0), 64'd0);
    run_op(32'd12, 32'd12);
    check("after_reset", product_o, 64'd144);

    // 6: back-to-back random ops with start held high
    spacing_en = 1'b1;
    seen_first = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    start_i = 1'b1;
    exp_q.push_back(mul_model(a_i, b_i));
    for (int op = 0; op < 1000; op++) begin
      @(posedge clk);
      if (op == 999) begin
        #1 start_i = 1'b0;
      end else begin
        // Next acceptance is BITS+2 edges later; operands in between are junk.
        for (int k = 0; k < BITS + 1; k++) begin
          @(negedge clk);
          a_i = $urandom;
          b_i = $urandom;
        end
        @(negedge clk);
        a_i = $urandom;
        b_i = $urandom;
        exp_q.push_back(mul_model(a_i, b_i));
      end
    end
    drain = 0;
    while (exp_q.size() != 0 && drain < 100) begin
      @(negedge clk);
      drain++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    spacing_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_multiplier
